// File: rtl/irig_pkg.sv
// irig_pkg: constants and types shared by the IRIG-B encoder and decoder.
//   - pulse widths in ms for zero / one / marker symbols
//   - frame length, ms per bit, marker positions, field start positions and widths
//   - FSM state encoding and the captured-time shadow record
package irig_pkg;

    localparam int IRIG_BITS       = 100;
    localparam int IRIG_MS_PER_BIT = 10;

    localparam int IRIG_W_ZERO = 2;
    localparam int IRIG_W_ONE  = 5;
    localparam int IRIG_W_MARK = 8;

    // Markers: Pr at 0, P1..P9 at 9,19,...,89, P0 at 99
    localparam int IRIG_POS_PR      = 0;
    localparam int IRIG_POS_P0      = 99;
    localparam int IRIG_MARK_FIRST  = 9;
    localparam int IRIG_MARK_STRIDE = 10;

    // Field start positions / widths (every field LSB first)
    localparam int F_SEC_U  = 1;   localparam int W_SEC_U  = 4;
    localparam int F_SEC_T  = 6;   localparam int W_SEC_T  = 3;
    localparam int F_MIN_U  = 10;  localparam int W_MIN_U  = 4;
    localparam int F_MIN_T  = 15;  localparam int W_MIN_T  = 3;
    localparam int F_HOUR_U = 20;  localparam int W_HOUR_U = 4;
    localparam int F_HOUR_T = 25;  localparam int W_HOUR_T = 2;
    localparam int F_DAY_U  = 30;  localparam int W_DAY_U  = 4;
    localparam int F_DAY_T  = 35;  localparam int W_DAY_T  = 4;
    localparam int F_DAY_H  = 40;  localparam int W_DAY_H  = 2;
    localparam int F_YEAR_U = 50;  localparam int W_YEAR_U = 4;
    localparam int F_YEAR_T = 55;  localparam int W_YEAR_T = 4;
    localparam int F_CTRL_L = 60;  localparam int W_CTRL_L = 9;
    localparam int F_CTRL_H = 70;  localparam int W_CTRL_H = 9;
    localparam int F_SBS_L  = 80;  localparam int W_SBS_L  = 9;
    localparam int F_SBS_H  = 90;  localparam int W_SBS_H  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } irig_state_t;

    typedef struct packed {
        logic [17:0] ctrl;
        logic [16:0] sbs;
        logic [7:0]  year;
        logic [9:0]  day;
        logic [5:0]  hour;
        logic [6:0]  min;
        logic [6:0]  sec;
    } irig_time_t;

    function automatic logic [IRIG_BITS-1:0] irig_mark_mask();
        logic [IRIG_BITS-1:0] m;
        m = '0;
        m[IRIG_POS_PR] = 1'b1;
        for (int i = IRIG_MARK_FIRST; i <= IRIG_POS_P0; i += IRIG_MARK_STRIDE) begin
            m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [IRIG_BITS-1:0] IRIG_MARK_MASK = irig_mark_mask();

endpackage

// File: rtl/irig_bit_mux.sv
// irig_bit_mux: combinational lookup of one frame position.
//   i_bit_idx [6:0]  frame position 0..99
//   i_shadow         captured time record
//   o_is_mark        position is a marker
//   o_bit_val        data value at that position (0 for unused/marker positions)
import irig_pkg::*;

module irig_bit_mux (
    input  logic       [6:0] i_bit_idx,
    input  irig_time_t       i_shadow,
    output logic             o_is_mark,
    output logic             o_bit_val
);

    logic [IRIG_BITS-1:0] w_frame;
    logic [IRIG_BITS-1:0] w_mark;

    assign w_mark = IRIG_MARK_MASK;

    // Lay every field into its slot of a flat 100-bit image, then pick one bit.
    always_comb begin
        w_frame = '0;
        w_frame[F_SEC_U  +: W_SEC_U ] = i_shadow.sec[3:0];
        w_frame[F_SEC_T  +: W_SEC_T ] = i_shadow.sec[6:4];
        w_frame[F_MIN_U  +: W_MIN_U ] = i_shadow.min[3:0];
        w_frame[F_MIN_T  +: W_MIN_T ] = i_shadow.min[6:4];
        w_frame[F_HOUR_U +: W_HOUR_U] = i_shadow.hour[3:0];
        w_frame[F_HOUR_T +: W_HOUR_T] = i_shadow.hour[5:4];
        w_frame[F_DAY_U  +: W_DAY_U ] = i_shadow.day[3:0];
        w_frame[F_DAY_T  +: W_DAY_T ] = i_shadow.day[7:4];
        w_frame[F_DAY_H  +: W_DAY_H ] = i_shadow.day[9:8];
        w_frame[F_YEAR_U +: W_YEAR_U] = i_shadow.year[3:0];
        w_frame[F_YEAR_T +: W_YEAR_T] = i_shadow.year[7:4];
        w_frame[F_CTRL_L +: W_CTRL_L] = i_shadow.ctrl[8:0];
        w_frame[F_CTRL_H +: W_CTRL_H] = i_shadow.ctrl[17:9];
        w_frame[F_SBS_L  +: W_SBS_L ] = i_shadow.sbs[8:0];
        w_frame[F_SBS_H  +: W_SBS_H ] = i_shadow.sbs[16:9];
    end

    assign o_is_mark = w_mark[i_bit_idx];
    assign o_bit_val = w_frame[i_bit_idx];

endmodule

// File: rtl/irig_encoder.sv
// irig_encoder: IRIG-B DC level-shift frame generator aligned to a local PPS.
// Optional feature macro: IRIG_CTRL_EN (adds ctrl_bits input carried on bits 60-68 / 70-78).
// Ports:
//   clk, rst (async, active-high)
//   enable             run request; low forces idle
//   pps_in             local PPS, synchronous to clk
//   sec/min/hour/day/year_bcd, sbs   time to transmit, sampled when time_load is high
//   ctrl_bits [17:0]   control field (only with IRIG_CTRL_EN)
//   time_load          1-cycle strobe, combinational: inputs are captured on this cycle
//   irig_out           registered DCLS output
//   pps_out            1-cycle pulse on the first high cycle of Pr
//   locked             high while running
//   sync_err           1-cycle pulse for a pps_in edge off the frame boundary
import irig_pkg::*;

module irig_encoder #(
    parameter int CLKS_PER_MS = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pps_in,
    input  logic [6:0]  sec_bcd,
    input  logic [6:0]  min_bcd,
    input  logic [5:0]  hour_bcd,
    input  logic [9:0]  day_bcd,
    input  logic [7:0]  year_bcd,
    input  logic [16:0] sbs,
`ifdef IRIG_CTRL_EN
    input  logic [17:0] ctrl_bits,
`endif
    output logic        time_load,
    output logic        irig_out,
    output logic        pps_out,
    output logic        locked,
    output logic        sync_err
);

    localparam int DIV_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_MS - 1);

    irig_state_t      r_state;
    logic             r_pps_q;
    logic [DIV_W-1:0] r_ms_div;
    logic [3:0]       r_ms_cnt;
    logic [6:0]       r_bit_idx;
    irig_time_t       r_shadow;
    logic             r_irig;
    logic             r_pps_out;
    logic             r_locked;
    logic             r_sync_err;

    irig_time_t       w_time_in;
    logic             w_pps_edge;
    logic             w_div_last;
    logic             w_ms_last;
    logic             w_bit_last;
    logic             w_frame_end;
    logic [DIV_W-1:0] w_div_nxt;
    logic [3:0]       w_ms_nxt;
    logic [6:0]       w_bit_nxt;
    logic             w_is_mark;
    logic             w_bit_val;
    logic [3:0]       w_width;
    logic             w_level;
    logic             w_capture_arm;
    logic             w_reload_run;

    always_comb begin
        w_time_in      = '0;
        w_time_in.sec  = sec_bcd;
        w_time_in.min  = min_bcd;
        w_time_in.hour = hour_bcd;
        w_time_in.day  = day_bcd;
        w_time_in.year = year_bcd;
        w_time_in.sbs  = sbs;
`ifdef IRIG_CTRL_EN
        w_time_in.ctrl = ctrl_bits;
`else
        w_time_in.ctrl = '0;
`endif
    end

    assign w_pps_edge  = pps_in & ~r_pps_q;
    assign w_div_last  = (r_ms_div == DIV_LAST);
    assign w_ms_last   = (r_ms_cnt == 4'(IRIG_MS_PER_BIT - 1));
    assign w_bit_last  = (r_bit_idx == 7'(IRIG_BITS - 1));
    // Last cycle of the frame: an aligned PPS edge lands here.
    assign w_frame_end = w_div_last & w_ms_last & w_bit_last;

    assign w_div_nxt = w_div_last ? '0 : r_ms_div + DIV_W'(1);
    assign w_ms_nxt  = w_div_last ? (w_ms_last ? 4'd0 : r_ms_cnt + 4'd1) : r_ms_cnt;
    assign w_bit_nxt = (w_div_last & w_ms_last) ? (w_bit_last ? 7'd0 : r_bit_idx + 7'd1)
                                                : r_bit_idx;

    // Output level is resolved for the position the counters move to, so the
    // registered irig_out lines up with the counter values it is shown with.
    irig_bit_mux u_bit_mux (
        .i_bit_idx (w_bit_nxt),
        .i_shadow  (r_shadow),
        .o_is_mark (w_is_mark),
        .o_bit_val (w_bit_val)
    );

    assign w_width = w_is_mark ? 4'(IRIG_W_MARK) : (w_bit_val ? 4'(IRIG_W_ONE) : 4'(IRIG_W_ZERO));
    assign w_level = (w_ms_nxt < w_width);

    assign w_capture_arm = (r_state == ST_ARM) & enable & w_pps_edge;
    // Reload at the start of P0 so the new time is ready for bit 1 of the next frame;
    // P0 and Pr are markers, so swapping the shadow here never disturbs a data bit.
    assign w_reload_run  = (r_state == ST_RUN) & enable & w_bit_last &
                           (r_ms_cnt == 4'd0) & (r_ms_div == '0);
    assign time_load     = w_capture_arm | w_reload_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pps_q    <= 1'b0;
            r_ms_div   <= '0;
            r_ms_cnt   <= 4'd0;
            r_bit_idx  <= 7'd0;
            r_shadow   <= '0;
            r_irig     <= 1'b0;
            r_pps_out  <= 1'b0;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_pps_q    <= pps_in;
            r_pps_out  <= 1'b0;
            r_sync_err <= 1'b0;
            if (!enable) begin
                r_state   <= ST_IDLE;
                r_ms_div  <= '0;
                r_ms_cnt  <= 4'd0;
                r_bit_idx <= 7'd0;
                r_irig    <= 1'b0;
                r_locked  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (w_pps_edge) begin
                            r_state   <= ST_RUN;
                            r_ms_div  <= '0;
                            r_ms_cnt  <= 4'd0;
                            r_bit_idx <= 7'd0;
                            r_shadow  <= w_time_in;
                            r_irig    <= 1'b1;
                            r_pps_out <= 1'b1;
                            r_locked  <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        r_ms_div  <= w_div_nxt;
                        r_ms_cnt  <= w_ms_nxt;
                        r_bit_idx <= w_bit_nxt;
                        r_irig    <= w_level;
                        r_pps_out <= w_frame_end;
                        if (w_reload_run) begin
                            r_shadow <= w_time_in;
                        end
                        if (w_pps_edge && !w_frame_end) begin
                            r_sync_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign irig_out = r_irig;
    assign pps_out  = r_pps_out;
    assign locked   = r_locked;
    assign sync_err = r_sync_err;

endmodule

// File: tb/tb_irig_encoder.sv
// tb_irig_encoder: scoreboard bench for irig_encoder with CLKS_PER_MS = 4.
// Expected pulse widths are queued as frames are started; a monitor measures
// every irig_out high pulse and compares it with the queue head.
module tb_irig_encoder;

    localparam int CPM = 4;

`ifdef IRIG_CTRL_EN
    localparam logic [17:0] CTRL_VAL = 18'h2AAAA;
`else
    localparam logic [17:0] CTRL_VAL = 18'h0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        pps_in;
    logic [6:0]  sec_bcd;
    logic [6:0]  min_bcd;
    logic [5:0]  hour_bcd;
    logic [9:0]  day_bcd;
    logic [7:0]  year_bcd;
    logic [16:0] sbs;
    logic [17:0] ctrl_bits;
    logic        time_load;
    logic        irig_out;
    logic        pps_out;
    logic        locked;
    logic        sync_err;

    always #5 clk = ~clk;

    irig_encoder #(.CLKS_PER_MS(CPM)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .pps_in    (pps_in),
        .sec_bcd   (sec_bcd),
        .min_bcd   (min_bcd),
        .hour_bcd  (hour_bcd),
        .day_bcd   (day_bcd),
        .year_bcd  (year_bcd),
        .sbs       (sbs),
`ifdef IRIG_CTRL_EN
        .ctrl_bits (ctrl_bits),
`endif
        .time_load (time_load),
        .irig_out  (irig_out),
        .pps_out   (pps_out),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    typedef struct {
        int w;
        int fr;
        int bi;
    } exp_t;

    exp_t exp_q[$];
    int   tl_q[$];
    int   pp_q[$];
    int   se_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_mis = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic sample();
        #3;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Expected frame image built from the field layout, then converted to
    // high-time in clock cycles: marker 8 ms, one 5 ms, zero 2 ms.
    task automatic push_frame(input int fr, input logic [6:0] s, input logic [6:0] m,
                              input logic [5:0] h, input logic [9:0] d, input logic [7:0] y,
                              input logic [16:0] sb, input logic [17:0] ct);
        logic [99:0] b;
        exp_t e;
        b = '0;
        for (int k = 0; k < 4; k++) b[1 + k]  = s[k];
        for (int k = 0; k < 3; k++) b[6 + k]  = s[4 + k];
        for (int k = 0; k < 4; k++) b[10 + k] = m[k];
        for (int k = 0; k < 3; k++) b[15 + k] = m[4 + k];
        for (int k = 0; k < 4; k++) b[20 + k] = h[k];
        for (int k = 0; k < 2; k++) b[25 + k] = h[4 + k];
        for (int k = 0; k < 4; k++) b[30 + k] = d[k];
        for (int k = 0; k < 4; k++) b[35 + k] = d[4 + k];
        for (int k = 0; k < 2; k++) b[40 + k] = d[8 + k];
        for (int k = 0; k < 4; k++) b[50 + k] = y[k];
        for (int k = 0; k < 4; k++) b[55 + k] = y[4 + k];
        for (int k = 0; k < 9; k++) b[60 + k] = ct[k];
        for (int k = 0; k < 9; k++) b[70 + k] = ct[9 + k];
        for (int k = 0; k < 9; k++) b[80 + k] = sb[k];
        for (int k = 0; k < 8; k++) b[90 + k] = sb[9 + k];
        for (int k = 0; k < 100; k++) begin
            e.fr = fr;
            e.bi = k;
            if (k == 0 || (k % 10) == 9) e.w = 8 * CPM;
            else if (b[k])               e.w = 5 * CPM;
            else                         e.w = 2 * CPM;
            exp_q.push_back(e);
        end
    endtask

    // Pulse-width monitor
    initial begin
        int hi;
        hi = 0;
        forever begin
            @(negedge clk);
            if (irig_out === 1'b1) begin
                hi++;
            end else if (hi > 0) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL pulse unexpected: width %0d, required none", hi);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (hi != e.w) begin
                        n_mis++;
                        $display("FAIL pulse f%0d b%0d: width %0d expected %0d", e.fr, e.bi, hi, e.w);
                    end else begin
                        $display("ok   pulse f%0d b%0d: width %0d", e.fr, e.bi, hi);
                    end
                end
                hi = 0;
            end
        end
    end

    // Event recorders (cycle stamps of strobes)
    initial begin
        forever begin
            @(negedge clk);
            if (time_load === 1'b1) tl_q.push_back(cyc);
            if (pps_out === 1'b1)   pp_q.push_back(cyc);
            if (sync_err === 1'b1)  se_q.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int e;
        int s3;
        int e2;
        rst = 1'b1; enable = 1'b0; pps_in = 1'b0;
        sec_bcd = '0; min_bcd = '0; hour_bcd = '0; day_bcd = '0; year_bcd = '0; sbs = '0;
        ctrl_bits = CTRL_VAL;

        repeat (3) tick();
        sample();
        chk("reset outputs", {59'd0, irig_out, locked, pps_out, time_load, sync_err}, 64'd0);
        tick();
        rst = 1'b0;

        // 1: enabled but no PPS for 10 ms
        enable = 1'b1;
        repeat (40) tick();
        sample();
        chk("no pps irig_out", irig_out, 0);
        chk("no pps locked", locked, 0);
        chk("no pps time_load count", tl_q.size(), 0);

        // 2: first frame 23:59:58 day 366 yr 24 sbs 86398
        tick();
        sec_bcd = 7'h58; min_bcd = 7'h59; hour_bcd = 6'h23;
        day_bcd = 10'h366; year_bcd = 8'h24; sbs = 17'd86398;
        pps_in = 1'b1;
        e = cyc;
        push_frame(1, 7'h58, 7'h59, 6'h23, 10'h366, 8'h24, 17'd86398, CTRL_VAL);
        tick();
        pps_in = 1'b0;
        sample();
        chk("first irig_out", irig_out, 1);
        chk("first pps_out", pps_out, 1);
        chk("first locked", locked, 1);
        chk("arm time_load cycle", (tl_q.size() > 0) ? tl_q[0] : -1, e);

        // 3: second frame carries 23:59:59 sbs 86399; frame 3 reuses it
        sec_bcd = 7'h59; sbs = 17'd86399;
        push_frame(2, 7'h59, 7'h59, 6'h23, 10'h366, 8'h24, 17'd86399, CTRL_VAL);
        push_frame(3, 7'h59, 7'h59, 6'h23, 10'h366, 8'h24, 17'd86399, CTRL_VAL);

        // Aligned PPS on the frame-boundary cycle: must be ignored
        tick_until(e + 4000);
        pps_in = 1'b1;
        tick();
        pps_in = 1'b0;
        sample();
        chk("frame2 pps_out", pps_out, 1);
        chk("boundary sync_err", sync_err, 0);

        // 4: misaligned PPS at frame-2 cycle 1234
        tick_until(e + 4001 + 1234);
        pps_in = 1'b1;
        tick();
        pps_in = 1'b0;
        sample();
        chk("sync_err pulse", sync_err, 1);
        tick();
        sample();
        chk("sync_err cleared", sync_err, 0);

        // 5: drop enable in the low part of frame-3 bit 45
        s3 = e + 8001;
        tick_until(s3 + 1830);
        enable = 1'b0;
        tick();
        sample();
        chk("drop irig_out", irig_out, 0);
        chk("drop locked", locked, 0);
        chk("pulses left after bit 45", exp_q.size(), 54);
        exp_q.delete();

        chk("time_load count", tl_q.size(), 3);
        chk("time_load frame1 reload", (tl_q.size() > 1) ? tl_q[1] : -1, e + 3961);
        chk("time_load frame2 reload", (tl_q.size() > 2) ? tl_q[2] : -1, e + 7961);
        chk("pps_out count", pp_q.size(), 3);
        chk("pps_out frame1", (pp_q.size() > 0) ? pp_q[0] : -1, e + 1);
        chk("pps_out frame2", (pp_q.size() > 1) ? pp_q[1] : -1, e + 4001);
        chk("pps_out frame3", (pp_q.size() > 2) ? pp_q[2] : -1, s3);
        chk("sync_err count", se_q.size(), 1);
        chk("sync_err cycle", (se_q.size() > 0) ? se_q[0] : -1, e + 5236);

        // Re-enable and restart with 12:34:56 day 123 yr 25 sbs 45296
        repeat (5) tick();
        sample();
        chk("idle irig_out", irig_out, 0);
        tick();
        enable = 1'b1;
        repeat (3) tick();
        tl_q.delete(); pp_q.delete(); se_q.delete();
        sec_bcd = 7'h56; min_bcd = 7'h34; hour_bcd = 6'h12;
        day_bcd = 10'h123; year_bcd = 8'h25; sbs = 17'd45296;
        tick();
        pps_in = 1'b1;
        e2 = cyc;
        push_frame(4, 7'h56, 7'h34, 6'h12, 10'h123, 8'h25, 17'd45296, CTRL_VAL);
        tick();
        pps_in = 1'b0;
        sample();
        chk("restart irig_out", irig_out, 1);
        chk("restart pps_out", pps_out, 1);
        chk("restart locked", locked, 1);

        tick_until(e2 + 1 + 3995);
        enable = 1'b0;
        repeat (20) tick();
        sample();
        chk("restart pulses outstanding", exp_q.size(), 0);
        chk("restart time_load count", tl_q.size(), 2);
        chk("restart time_load arm", (tl_q.size() > 0) ? tl_q[0] : -1, e2);
        chk("restart time_load reload", (tl_q.size() > 1) ? tl_q[1] : -1, e2 + 3961);
        chk("restart pps_out count", pp_q.size(), 1);
        chk("restart pps_out cycle", (pp_q.size() > 0) ? pp_q[0] : -1, e2 + 1);
        chk("final irig_out", irig_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
